// File: rtl/log_capture_ram.sv
// log_capture_ram
// Two-channel sample capture buffer. A rising edge on i_run starts a capture
// that writes one {data1, data0} word per valid sample into an internal
// dual-port RAM until all 2^NB_ADDR words are written, then raises o_full.
// The micro reads the RAM back by address with one cycle of latency.
//
// Optional feature macro: LOG_CAPTURE_TRIGGER_EN
//   Adds the i_trigger port and an ARMED state between IDLE and CAPTURE.
//
// Ports:
//   clock        in   system clock, rising edge
//   i_reset      in   synchronous active-high reset
//   i_run        in   capture run level; a rising edge starts a capture
//   i_valid      in   sample strobe
//   i_data0      in   channel 0 sample (NB_DATA)
//   i_data1      in   channel 1 sample (NB_DATA)
//   i_trigger    in   capture trigger (LOG_CAPTURE_TRIGGER_EN only)
//   i_read_addr  in   micro read address (NB_ADDR)
//   o_read_data  out  registered read-first RAM word, {data1, data0}
//   o_full       out  all 2^NB_ADDR words written
//   o_busy       out  capture in progress (ARMED or CAPTURE)
//   o_wr_count   out  words written in the current capture (NB_ADDR+1)

module log_capture_ram #(
   parameter int NB_DATA = 16,
   parameter int NB_ADDR = 11
) (
   input  logic                   clock,
   input  logic                   i_reset,
   input  logic                   i_run,
   input  logic                   i_valid,
   input  logic [NB_DATA-1:0]     i_data0,
   input  logic [NB_DATA-1:0]     i_data1,
`ifdef LOG_CAPTURE_TRIGGER_EN
   input  logic                   i_trigger,
`endif
   input  logic [NB_ADDR-1:0]     i_read_addr,
   output logic [2*NB_DATA-1:0]   o_read_data,
   output logic                   o_full,
   output logic                   o_busy,
   output logic [NB_ADDR:0]       o_wr_count
);

   localparam int DEPTH = 1 << NB_ADDR;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
`ifdef LOG_CAPTURE_TRIGGER_EN
      ARMED   = 2'd1,
`endif
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   logic [2*NB_DATA-1:0] mem [DEPTH];

   state_t               state;
   logic                 run_d;
   logic                 run_ok;
   logic [NB_ADDR-1:0]   wr_ptr;
   logic                 run_rise;
   logic                 wr_en;
   logic                 last_wr;

   // run_d clears on reset, so a run level held through reset would look like
   // a fresh rising edge. run_ok stays low until i_run has been seen low once,
   // forcing the micro to drop and re-raise run before a capture can start.
   assign run_rise = i_run & ~run_d & run_ok;

   // i_run low always wins, so no sample is written in the deassert cycle.
   always_comb begin
      wr_en = 1'b0;
      if (i_run && i_valid) begin
         if (state == CAPTURE) wr_en = 1'b1;
`ifdef LOG_CAPTURE_TRIGGER_EN
         // The sample coincident with the trigger is the first word captured.
         if (state == ARMED && i_trigger) wr_en = 1'b1;
`endif
      end
   end

   assign last_wr = wr_en && (wr_ptr == {NB_ADDR{1'b1}});

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state      <= IDLE;
         run_d      <= 1'b0;
         run_ok     <= 1'b0;
         wr_ptr     <= '0;
         o_wr_count <= '0;
         o_full     <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         run_d  <= i_run;
         run_ok <= run_ok | ~i_run;
         if (!i_run) begin
            // Count and RAM are kept for readback; only the flags drop.
            state  <= IDLE;
            o_full <= 1'b0;
            o_busy <= 1'b0;
         end else begin
            if (wr_en) begin
               wr_ptr     <= wr_ptr + 1'b1;
               o_wr_count <= o_wr_count + 1'b1;
            end
            case (state)
               IDLE: begin
                  if (run_rise) begin
                     wr_ptr     <= '0;
                     o_wr_count <= '0;
                     o_busy     <= 1'b1;
`ifdef LOG_CAPTURE_TRIGGER_EN
                     state      <= ARMED;
`else
                     state      <= CAPTURE;
`endif
                  end
               end
`ifdef LOG_CAPTURE_TRIGGER_EN
               ARMED: begin
                  if (i_trigger) state <= CAPTURE;
               end
`endif
               CAPTURE: begin
                  if (last_wr) begin
                     state  <= DONE;
                     o_full <= 1'b1;
                     o_busy <= 1'b0;
                  end
               end
               DONE:    state <= DONE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // RAM array is never reset; writes are suppressed while reset is held.
   always_ff @(posedge clock) begin
      if (wr_en && !i_reset) mem[wr_ptr] <= {i_data1, i_data0};
   end

   // Read-first: a same-cycle write to this address shows up one cycle later.
   always_ff @(posedge clock) begin
      if (i_reset) o_read_data <= '0;
      else         o_read_data <= mem[i_read_addr];
   end

endmodule
